prog_clock_divider: RTL and testbench

//  Multi-channel, runtime-programmable clock divider. It replaces fixed single-DIVISOR dividers in the
//  KGP_miniRISC board top. Each channel produces a divided clock with programmable high time and a
//  one-cycle tick. New settings take effect glitch-free at the channel's next period boundary.

---
 rtl/prog_clock_divider_pkg.sv | 15 +
 rtl/prog_clock_divider_channel.sv | 149 ++++++++++++++
 rtl/prog_clock_divider.sv | 60 ++++++
 tb/tb_prog_clock_divider.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clock_divider_pkg.sv
// Shared definitions for the programmable clock divider.
//   CH_IDX_W : width of the channel index carried on cfg_ch
//   MIN_DIV  : smallest usable divisor; smaller divisors are raised to this
//   ch_state_t : per-channel run state
package prog_clock_divider_pkg;

  localparam int unsigned CH_IDX_W = 4;
  localparam int unsigned MIN_DIV  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/prog_clock_divider_channel.sv
// One divider channel: active and shadow divisor/high-time registers,
// clamping of the programmed values, and the IDLE/RUN state machine.
// Ports:
//   clk_in, rst_n      : clock, asynchronous active-low reset
//   en                 : run enable
//   wr                 : write strobe for this channel
//   cfg_div, cfg_high  : values written into the shadow registers
//   clk_out            : divided clock (registered)
//   tick               : one-cycle pulse on the first cycle of each period
//   pending            : shadow holds settings not yet applied
module clkdiv_channel
  import prog_clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DIV_DEF  = 1000000,
  parameter int unsigned HIGH_DEF = DIV_DEF / 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
    return (d < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : d;
  endfunction

  function automatic logic [WIDTH-1:0] eff_high(input logic [WIDTH-1:0] h,
                                                input logic [WIDTH-1:0] deff);
    if (h == '0)   return WIDTH'(1);
    if (h >= deff) return deff - WIDTH'(1);
    return h;
  endfunction

  ch_state_t        state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] act_div, act_div_nxt, act_high, act_high_nxt;
  logic [WIDTH-1:0] sh_div, sh_div_nxt, sh_high, sh_high_nxt;
  logic             pending_nxt, clk_nxt, tick_nxt;
  logic [WIDTH-1:0] div_eff, div_eff_nxt, high_eff_nxt;
  logic             wrap;

  assign div_eff = eff_div(act_div);
  assign wrap    = (cnt == div_eff - WIDTH'(1));

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    act_div_nxt  = act_div;
    act_high_nxt = act_high;
    sh_div_nxt   = sh_div;
    sh_high_nxt  = sh_high;
    pending_nxt  = pending;

    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (pending) begin
          act_div_nxt  = sh_div;
          act_high_nxt = sh_high;
          pending_nxt  = 1'b0;
        end
        if (wr) begin
          sh_div_nxt  = cfg_div;
          sh_high_nxt = cfg_high;
          pending_nxt = 1'b1;
        end
        if (en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          if (wr) begin
            sh_div_nxt  = cfg_div;
            sh_high_nxt = cfg_high;
            pending_nxt = 1'b1;
          end
        end else if (wrap) begin
          cnt_nxt = '0;
          // A write landing on the wrap cycle bypasses the shadow so the
          // new period starts immediately and nothing is left pending.
          if (wr) begin
            act_div_nxt  = cfg_div;
            act_high_nxt = cfg_high;
            sh_div_nxt   = cfg_div;
            sh_high_nxt  = cfg_high;
            pending_nxt  = 1'b0;
          end else if (pending) begin
            act_div_nxt  = sh_div;
            act_high_nxt = sh_high;
            pending_nxt  = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
          if (wr) begin
            sh_div_nxt  = cfg_div;
            sh_high_nxt = cfg_high;
            pending_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output compare uses the settings in force for the next cycle, so the
  // first cycle of a freshly applied period already reflects the new H.
  always_comb begin
    div_eff_nxt  = eff_div(act_div_nxt);
    high_eff_nxt = eff_high(act_high_nxt, div_eff_nxt);
    clk_nxt      = 1'b0;
    tick_nxt     = 1'b0;
    if (state_nxt == ST_RUN) begin
      clk_nxt  = (cnt_nxt < high_eff_nxt);
      tick_nxt = (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      act_div  <= WIDTH'(DIV_DEF);
      act_high <= WIDTH'(HIGH_DEF);
      sh_div   <= WIDTH'(DIV_DEF);
      sh_high  <= WIDTH'(HIGH_DEF);
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      act_div  <= act_div_nxt;
      act_high <= act_high_nxt;
      sh_div   <= sh_div_nxt;
      sh_high  <= sh_high_nxt;
      pending  <= pending_nxt;
      clk_out  <= clk_nxt;
      tick     <= tick_nxt;
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider.
// Ports:
//   clk_in    : sole clock
//   rst_n     : asynchronous active-low reset
//   en        : per-channel run enable
//   cfg_we    : config write strobe (one cycle per write)
//   cfg_ch    : channel index of the write; indices >= N_CH are ignored
//   cfg_div   : new divisor
//   cfg_high  : new high time
//   clk_out   : divided clocks
//   tick      : per-channel pulse on the first cycle of each period
//   pending   : per-channel flag, shadow settings not yet applied
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DIV_DEF  = 1000000,
  parameter int unsigned HIGH_DEF = DIV_DEF / 2
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     en,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [WIDTH-1:0]    cfg_high,
  output logic [N_CH-1:0]     clk_out,
  output logic [N_CH-1:0]     tick,
  output logic [N_CH-1:0]     pending
);

  logic [N_CH-1:0] wr;

  always_comb begin
    wr = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr[i] = cfg_we && (cfg_ch == CH_IDX_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clkdiv_channel #(
      .WIDTH   (WIDTH),
      .DIV_DEF (DIV_DEF),
      .HIGH_DEF(HIGH_DEF)
    ) u_ch (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en[g]),
      .wr      (wr[g]),
      .cfg_div (cfg_div),
      .cfg_high(cfg_high),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Testbench for prog_clock_divider: directed tables, hand-written corner
// sequences and a randomized run against a period-position reference model.
module tb_prog_clock_divider;
  import prog_clock_divider_pkg::*;

  localparam int unsigned N_CH     = 4;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DIV_DEF  = 10;
  localparam int unsigned HIGH_DEF = 5;

  logic                clk_in = 1'b0;
  logic                rst_n  = 1'b1;
  logic [N_CH-1:0]     en     = '0;
  logic                cfg_we = 1'b0;
  logic [CH_IDX_W-1:0] cfg_ch = '0;
  logic [WIDTH-1:0]    cfg_div  = '0;
  logic [WIDTH-1:0]    cfg_high = '0;
  logic [N_CH-1:0]     clk_out, tick, pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: whether the channel runs, its position inside the
  // current period, the applied and shadow settings, and the pending flag.
  int unsigned m_run[N_CH], m_pos[N_CH], m_ad[N_CH], m_ah[N_CH];
  int unsigned m_sd[N_CH], m_sh[N_CH], m_pend[N_CH];

  typedef struct {
    logic [N_CH-1:0] en;
    logic            exp_clk;
    logic            exp_tick;
  } t1_vec_t;

  typedef struct {
    int unsigned d;
    int unsigned h;
    int unsigned hi;
    int unsigned lo;
  } cv_t;

  t1_vec_t t1[20];
  cv_t     ctab[8];

  prog_clock_divider #(
    .N_CH    (N_CH),
    .WIDTH   (WIDTH),
    .DIV_DEF (DIV_DEF),
    .HIGH_DEF(HIGH_DEF)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_high(cfg_high),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  always #5 clk_in = ~clk_in;

  function automatic int unsigned c_div(int unsigned d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  function automatic int unsigned c_high(int unsigned h, int unsigned d);
    int unsigned de;
    de = c_div(d);
    if (h == 0) return 1;
    if (h >= de) return de - 1;
    return h;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_run[c] = 0; m_pos[c] = 0; m_pend[c] = 0;
      m_ad[c] = DIV_DEF; m_ah[c] = HIGH_DEF;
      m_sd[c] = DIV_DEF; m_sh[c] = HIGH_DEF;
    end
  endtask

  task automatic model_step();
    bit w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      w = cfg_we && (int'(cfg_ch) == c);
      if (m_run[c] == 0) begin
        if (m_pend[c] != 0) begin
          m_ad[c] = m_sd[c]; m_ah[c] = m_sh[c]; m_pend[c] = 0;
        end
        if (w) begin
          m_sd[c] = cfg_div; m_sh[c] = cfg_high; m_pend[c] = 1;
        end
        if (en[c]) begin
          m_run[c] = 1; m_pos[c] = 0;
        end
      end else if (!en[c]) begin
        m_run[c] = 0; m_pos[c] = 0;
        if (w) begin
          m_sd[c] = cfg_div; m_sh[c] = cfg_high; m_pend[c] = 1;
        end
      end else if (m_pos[c] == c_div(m_ad[c]) - 1) begin
        m_pos[c] = 0;
        if (w) begin
          m_ad[c] = cfg_div; m_ah[c] = cfg_high;
          m_sd[c] = cfg_div; m_sh[c] = cfg_high; m_pend[c] = 0;
        end else if (m_pend[c] != 0) begin
          m_ad[c] = m_sd[c]; m_ah[c] = m_sh[c]; m_pend[c] = 0;
        end
      end else begin
        m_pos[c]++;
        if (w) begin
          m_sd[c] = cfg_div; m_sh[c] = cfg_high; m_pend[c] = 1;
        end
      end
    end
  endtask

  function automatic logic [N_CH-1:0] exp_clk();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++)
      v[c] = (m_run[c] != 0) && (m_pos[c] < c_high(m_ah[c], m_ad[c]));
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_tick();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++)
      v[c] = (m_run[c] != 0) && (m_pos[c] == 0);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_pend();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = (m_pend[c] != 0);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("model_clk_out", 32'(clk_out), 32'(exp_clk()));
    chk("model_tick",    32'(tick),    32'(exp_tick()));
    chk("model_pending", 32'(pending), 32'(exp_pend()));
  endtask

  // One clock edge: advance the model with the inputs the DUT sampled,
  // then compare just after the edge.
  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
    check_all();
  endtask

  task automatic write_cfg(int unsigned ch, int unsigned d, int unsigned h);
    cfg_we   = 1'b1;
    cfg_ch   = CH_IDX_W'(ch);
    cfg_div  = WIDTH'(d);
    cfg_high = WIDTH'(h);
  endtask

  initial begin
    int idx;

    for (int k = 0; k < 20; k++) begin
      t1[k].en       = 4'b0001;
      t1[k].exp_clk  = (k % 10) < 5;
      t1[k].exp_tick = (k % 10) == 0;
    end
    ctab[0] = '{d: 0,  h: 5, hi: 1, lo: 1};
    ctab[1] = '{d: 1,  h: 0, hi: 1, lo: 1};
    ctab[2] = '{d: 6,  h: 9, hi: 5, lo: 1};
    ctab[3] = '{d: 4,  h: 1, hi: 1, lo: 3};
    ctab[4] = '{d: 10, h: 5, hi: 5, lo: 5};
    ctab[5] = '{d: 7,  h: 0, hi: 1, lo: 6};
    ctab[6] = '{d: 3,  h: 3, hi: 2, lo: 1};
    ctab[7] = '{d: 5,  h: 2, hi: 2, lo: 3};

    // Reset state, asserted before any clock edge.
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    chk("reset_clk_out", 32'(clk_out), 32'd0);
    chk("reset_tick",    32'(tick),    32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    step();
    step();
    @(negedge clk_in) rst_n = 1'b1;

    // Default settings on channel 0: 5 high / 5 low, tick on rise.
    for (int k = 0; k < 20; k++) begin
      en = t1[k].en;
      step();
      chk("t1_clk",  32'(clk_out[0]), 32'(t1[k].exp_clk));
      chk("t1_tick", 32'(tick[0]),    32'(t1[k].exp_tick));
    end

    // Clamp table on channel 2, programmed while idle.
    for (int i = 0; i < 8; i++) begin
      en[2] = 1'b0;
      write_cfg(2, ctab[i].d, ctab[i].h);
      step();
      chk("clamp_pend_set", 32'(pending[2]), 32'd1);
      cfg_we = 1'b0;
      step();
      chk("clamp_pend_clr", 32'(pending[2]), 32'd0);
      en[2] = 1'b1;
      for (int k = 0; k < int'(2 * (ctab[i].hi + ctab[i].lo)); k++) begin
        step();
        chk("clamp_clk",  32'(clk_out[2]),
            32'((k % int'(ctab[i].hi + ctab[i].lo)) < int'(ctab[i].hi)));
        chk("clamp_tick", 32'(tick[2]),
            32'((k % int'(ctab[i].hi + ctab[i].lo)) == 0));
      end
    end
    en[2] = 1'b0;
    step();

    // Channel 1: reprogram mid-period at cnt=3, old period completes.
    en[1] = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) step();
    write_cfg(1, 4, 1);
    step();
    cfg_we = 1'b0;
    chk("t2_pend_set", 32'(pending[1]), 32'd1);
    chk("t2_clk_cnt4", 32'(clk_out[1]), 32'd1);
    for (int k = 5; k <= 9; k++) begin
      step();
      chk("t2_old_clk", 32'(clk_out[1]), 32'd0);
    end
    chk("t2_pend_hold", 32'(pending[1]), 32'd1);
    step();
    chk("t2_wrap_clk",  32'(clk_out[1]), 32'd1);
    chk("t2_wrap_tick", 32'(tick[1]),    32'd1);
    chk("t2_wrap_pend", 32'(pending[1]), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t2_new_clk",  32'(clk_out[1]), 32'((k % 4) == 0));
      chk("t2_new_tick", 32'(tick[1]),    32'((k % 4) == 0));
    end

    // Channel 1: drop enable at cnt=2, then restart.
    step();
    step();
    en[1] = 1'b0;
    step();
    chk("t4_stop_clk",  32'(clk_out[1]), 32'd0);
    chk("t4_stop_tick", 32'(tick[1]),    32'd0);
    en[1] = 1'b1;
    step();
    chk("t4_start_clk",  32'(clk_out[1]), 32'd1);
    chk("t4_start_tick", 32'(tick[1]),    32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t4_clk",  32'(clk_out[1]), 32'((k % 4) == 0));
      chk("t4_tick", 32'(tick[1]),    32'((k % 4) == 0));
    end

    // Writes to channel indices outside the instance are ignored.
    write_cfg(N_CH, 3, 1);
    step();
    chk("t6_badch_pend", 32'(pending), 32'd0);
    write_cfg(15, 3, 1);
    step();
    chk("t6_badch15_pend", 32'(pending), 32'd0);
    cfg_we = 1'b0;

    // Channel 3: write on the exact wrap cycle applies immediately.
    en[3] = 1'b1;
    step();
    for (int k = 1; k <= 9; k++) step();
    write_cfg(3, 3, 2);
    step();
    cfg_we = 1'b0;
    chk("t6_wrap_clk",  32'(clk_out[3]), 32'd1);
    chk("t6_wrap_tick", 32'(tick[3]),    32'd1);
    chk("t6_wrap_pend", 32'(pending[3]), 32'd0);
    step();
    chk("t6_cnt1_clk", 32'(clk_out[3]), 32'd1);
    step();
    chk("t6_cnt2_clk", 32'(clk_out[3]), 32'd0);
    step();
    chk("t6_cnt0_tick", 32'(tick[3]), 32'd1);

    // Asynchronous reset mid-period with a write pending.
    write_cfg(0, 7, 3);
    step();
    cfg_we = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async_clk",  32'(clk_out), 32'd0);
    chk("t5_async_tick", 32'(tick),    32'd0);
    chk("t5_async_pend", 32'(pending), 32'd0);
    model_reset();
    en = '0;
    step();
    step();
    @(negedge clk_in) rst_n = 1'b1;
    en = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t5_default_clk", 32'(clk_out[0]), 32'(k < 5));
    end

    // Randomized enables and writes across all channels.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        idx = int'($urandom_range(0, N_CH - 1));
        en[idx] = ~en[idx];
      end
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_ch   = CH_IDX_W'($urandom_range(0, 5));
      cfg_div  = WIDTH'($urandom_range(0, 12));
      cfg_high = WIDTH'($urandom_range(0, 14));
      step();
    end
    cfg_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
